// File: rtl/dcache_pkg.sv
// Shared geometry, state encoding and address-field helpers for the data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned INDEX_W    = 5;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned NUM_BLOCKS = 1 << INDEX_W;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;
    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [BLOCK_W-1:0]  block_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFFSET_W-1:0];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic tag_t addr_tag(input addr_t a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    // Word 0 sits in the least significant 32 bits of a block.
    function automatic word_t block_word(input block_t blk, input offset_t off);
        return blk[32'(off) * WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Core-side load/store and memory-side request/ready signals of the data cache.
interface dcache_if
    import dcache_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             mem_read;
    logic             mem_write;
    addr_t            addr;
    word_t            wr_data;
    word_t            rd_data;
    logic             stall;
    logic             mm_rd_req;
    logic             mm_wr_req;
    addr_t            mm_addr;
    word_t            mm_wr_data;
    block_t           mm_rd_data;
    logic             mm_ready;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport slave (
        input  mem_read, mem_write, addr, wr_data, mm_rd_data, mm_ready,
        output rd_data, stall, mm_rd_req, mm_wr_req, mm_addr, mm_wr_data,
        output hit_cnt, miss_cnt
    );

    modport master (
        output mem_read, mem_write, addr, wr_data, mm_rd_data, mm_ready,
        input  rd_data, stall, mm_rd_req, mm_wr_req, mm_addr, mm_wr_data,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache with one lookup port,
// a whole-block refill port and a single-word store port.
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  index_t  lookup_index_i,
    input  tag_t    lookup_tag_i,
    output logic    hit_o,
    output block_t  lookup_block_o,
    input  logic    fill_en_i,
    input  index_t  fill_index_i,
    input  tag_t    fill_tag_i,
    input  block_t  fill_block_i,
    input  logic    wr_en_i,
    input  index_t  wr_index_i,
    input  offset_t wr_offset_i,
    input  word_t   wr_word_i
);
    logic [NUM_BLOCKS-1:0] valid_q;
    tag_t                  tag_q  [NUM_BLOCKS];
    block_t                data_q [NUM_BLOCKS];

    // Valid bits are the only state cleared by reset; a refill marks its line valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_index_i] <= 1'b1;
        end
    end

    // Tag/data storage: refills write the whole block, store hits patch one word.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fill_index_i]  <= fill_tag_i;
            data_q[fill_index_i] <= fill_block_i;
        end else if (wr_en_i) begin
            data_q[wr_index_i][32'(wr_offset_i) * WORD_W +: WORD_W] <= wr_word_i;
        end
    end

    // Combinational lookup.
    always_comb begin
        hit_o          = valid_q[lookup_index_i] && (tag_q[lookup_index_i] == lookup_tag_i);
        lookup_block_o = data_q[lookup_index_i];
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// saturating read-hit / read-miss counters.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
)(
    input  logic     clk,
    input  logic     rst,
    dcache_if.slave  bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    tag_t    a_tag;
    index_t  a_index;
    offset_t a_offset;
    logic    hit;
    block_t  lookup_block;
    logic    fill_en;
    logic    wr_en;
    logic    stall_c;
    word_t   rd_data_c;
    logic    mm_rd_req_c;
    logic    mm_wr_req_c;
    addr_t   mm_addr_c;
    word_t   mm_wr_data_c;

    // Split the word address into tag / index / word offset.
    always_comb begin
        a_tag    = addr_tag(bus.addr);
        a_index  = addr_index(bus.addr);
        a_offset = addr_offset(bus.addr);
    end

    dcache_line_store u_line_store (
        .clk            (clk),
        .rst            (rst),
        .lookup_index_i (a_index),
        .lookup_tag_i   (a_tag),
        .hit_o          (hit),
        .lookup_block_o (lookup_block),
        .fill_en_i      (fill_en),
        .fill_index_i   (a_index),
        .fill_tag_i     (a_tag),
        .fill_block_i   (bus.mm_rd_data),
        .wr_en_i        (wr_en),
        .wr_index_i     (a_index),
        .wr_offset_i    (a_offset),
        .wr_word_i      (bus.wr_data)
    );

    // State and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next state, core-facing stall/data, array update strobes and counter updates.
    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        rd_data_c  = '0;
        fill_en    = 1'b0;
        wr_en      = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_write) begin
                    stall_c = 1'b1;
                    state_d = WR_THRU;
                end else if (bus.mem_read) begin
                    if (hit) begin
                        rd_data_c = block_word(lookup_block, a_offset);
                        if (hit_cnt_q != {CNT_W{1'b1}}) begin
                            hit_cnt_d = hit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        stall_c = 1'b1;
                        state_d = RD_MISS;
                        if (miss_cnt_q != {CNT_W{1'b1}}) begin
                            miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            RD_MISS: begin
                if (bus.mm_ready) begin
                    rd_data_c = block_word(bus.mm_rd_data, a_offset);
                    fill_en   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            WR_THRU: begin
                if (bus.mm_ready) begin
                    wr_en   = hit;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory requests decode only from the registered state.
    always_comb begin
        mm_rd_req_c  = 1'b0;
        mm_wr_req_c  = 1'b0;
        mm_addr_c    = '0;
        mm_wr_data_c = '0;
        case (state_q)
            RD_MISS: begin
                mm_rd_req_c = 1'b1;
                mm_addr_c   = {a_tag, a_index, {OFFSET_W{1'b0}}};
            end
            WR_THRU: begin
                mm_wr_req_c  = 1'b1;
                mm_addr_c    = bus.addr;
                mm_wr_data_c = bus.wr_data;
            end
            default: begin
                mm_rd_req_c = 1'b0;
            end
        endcase
    end

    assign bus.stall      = stall_c;
    assign bus.rd_data    = rd_data_c;
    assign bus.mm_rd_req  = mm_rd_req_c;
    assign bus.mm_wr_req  = mm_wr_req_c;
    assign bus.mm_addr    = mm_addr_c;
    assign bus.mm_wr_data = mm_wr_data_c;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed, table-driven bench for dcache_controller plus a narrow-counter
// instance for saturation.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dcache_if #(.CNT_W(16)) bus  ();
    dcache_if #(.CNT_W(4))  bus4 ();

    dcache_controller #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dcache_controller #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [9:0]   addr;
        logic [31:0]  wdata;
        logic         ready;
        logic [127:0] mmdata;
        logic         e_stall;
        logic [31:0]  e_rdata;
        logic         e_rdreq;
        logic         e_wrreq;
        logic [9:0]   e_mmaddr;
        logic [31:0]  e_mmwdata;
        logic [15:0]  e_hit;
        logic [15:0]  e_miss;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    logic [127:0] blk1;
    logic [127:0] blk2;

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
        input logic ready, input logic [127:0] mmdata,
        input logic e_stall, input logic [31:0] e_rdata, input logic e_rdreq, input logic e_wrreq,
        input logic [9:0] e_mmaddr, input logic [31:0] e_mmwdata,
        input logic [15:0] e_hit, input logic [15:0] e_miss);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.ready = ready; v.mmdata = mmdata;
        v.e_stall = e_stall; v.e_rdata = e_rdata; v.e_rdreq = e_rdreq; v.e_wrreq = e_wrreq;
        v.e_mmaddr = e_mmaddr; v.e_mmwdata = e_mmwdata; v.e_hit = e_hit; v.e_miss = e_miss;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic ready, input logic [127:0] mmdata);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.addr       = addr;
        bus.wr_data    = wdata;
        bus.mm_ready   = ready;
        bus.mm_rd_data = mmdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 128'h0);
        bus4.mem_read   = 1'b0;
        bus4.mem_write  = 1'b0;
        bus4.addr       = 10'h000;
        bus4.wr_data    = 32'h0;
        bus4.mm_ready   = 1'b0;
        bus4.mm_rd_data = 128'h0;

        blk1 = {32'h33333333, 32'h22222222, 32'h11111111, 32'hAAAA0000};
        blk2 = {32'h77777777, 32'h66666666, 32'h44444444, 32'h55550000};

        //        rd    wr    addr     wdata         rdy   mmdata  stall rdata          rdreq wrreq mmaddr   mmwdata       hit miss
        vt[0]  = mk(1'b1, 1'b0, 10'h004, 32'h0,        1'b0, 128'h0, 1'b1, 32'h0,        1'b0, 1'b0, 10'h000, 32'h0,        16'd0, 16'd0);
        vt[1]  = mk(1'b1, 1'b0, 10'h004, 32'h0,        1'b0, 128'h0, 1'b1, 32'h0,        1'b1, 1'b0, 10'h004, 32'h0,        16'd0, 16'd1);
        vt[2]  = mk(1'b1, 1'b0, 10'h004, 32'h0,        1'b0, 128'h0, 1'b1, 32'h0,        1'b1, 1'b0, 10'h004, 32'h0,        16'd0, 16'd1);
        vt[3]  = mk(1'b1, 1'b0, 10'h004, 32'h0,        1'b1, blk1,   1'b0, 32'hAAAA0000, 1'b1, 1'b0, 10'h004, 32'h0,        16'd0, 16'd1);
        vt[4]  = mk(1'b1, 1'b0, 10'h005, 32'h0,        1'b0, 128'h0, 1'b0, 32'h11111111, 1'b0, 1'b0, 10'h000, 32'h0,        16'd0, 16'd1);
        vt[5]  = mk(1'b0, 1'b0, 10'h004, 32'h0,        1'b1, blk2,   1'b0, 32'h0,        1'b0, 1'b0, 10'h000, 32'h0,        16'd1, 16'd1);
        vt[6]  = mk(1'b0, 1'b1, 10'h005, 32'h12345678, 1'b0, 128'h0, 1'b1, 32'h0,        1'b0, 1'b0, 10'h000, 32'h0,        16'd1, 16'd1);
        vt[7]  = mk(1'b0, 1'b1, 10'h005, 32'h12345678, 1'b0, 128'h0, 1'b1, 32'h0,        1'b0, 1'b1, 10'h005, 32'h12345678, 16'd1, 16'd1);
        vt[8]  = mk(1'b0, 1'b1, 10'h005, 32'h12345678, 1'b1, 128'h0, 1'b0, 32'h0,        1'b0, 1'b1, 10'h005, 32'h12345678, 16'd1, 16'd1);
        vt[9]  = mk(1'b1, 1'b0, 10'h005, 32'h0,        1'b0, 128'h0, 1'b0, 32'h12345678, 1'b0, 1'b0, 10'h000, 32'h0,        16'd1, 16'd1);
        vt[10] = mk(1'b0, 1'b1, 10'h204, 32'hDEADBEEF, 1'b0, 128'h0, 1'b1, 32'h0,        1'b0, 1'b0, 10'h000, 32'h0,        16'd2, 16'd1);
        vt[11] = mk(1'b0, 1'b1, 10'h204, 32'hDEADBEEF, 1'b1, 128'h0, 1'b0, 32'h0,        1'b0, 1'b1, 10'h204, 32'hDEADBEEF, 16'd2, 16'd1);
        vt[12] = mk(1'b1, 1'b0, 10'h004, 32'h0,        1'b0, 128'h0, 1'b0, 32'hAAAA0000, 1'b0, 1'b0, 10'h000, 32'h0,        16'd2, 16'd1);
        vt[13] = mk(1'b1, 1'b0, 10'h204, 32'h0,        1'b0, 128'h0, 1'b1, 32'h0,        1'b0, 1'b0, 10'h000, 32'h0,        16'd3, 16'd1);
        vt[14] = mk(1'b1, 1'b0, 10'h204, 32'h0,        1'b1, blk2,   1'b0, 32'h55550000, 1'b1, 1'b0, 10'h204, 32'h0,        16'd3, 16'd2);
        vt[15] = mk(1'b1, 1'b0, 10'h006, 32'h0,        1'b0, 128'h0, 1'b1, 32'h0,        1'b0, 1'b0, 10'h000, 32'h0,        16'd3, 16'd2);
        vt[16] = mk(1'b1, 1'b0, 10'h006, 32'h0,        1'b0, 128'h0, 1'b1, 32'h0,        1'b1, 1'b0, 10'h004, 32'h0,        16'd3, 16'd3);

        // Reset state
        #2;
        chk("reset stall",     32'(bus.stall),     32'd0);
        chk("reset rd_data",   bus.rd_data,        32'd0);
        chk("reset mm_rd_req", 32'(bus.mm_rd_req), 32'd0);
        chk("reset mm_wr_req", 32'(bus.mm_wr_req), 32'd0);
        chk("reset hit_cnt",   32'(bus.hit_cnt),   32'd0);
        chk("reset miss_cnt",  32'(bus.miss_cnt),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: miss/refill, hit, write-hit, write-miss no-allocate, conflict refill
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].ready, vt[i].mmdata);
            @(negedge clk);
            chk($sformatf("v%0d stall", i),      32'(bus.stall),      32'(vt[i].e_stall));
            chk($sformatf("v%0d rd_data", i),    bus.rd_data,         vt[i].e_rdata);
            chk($sformatf("v%0d mm_rd_req", i),  32'(bus.mm_rd_req),  32'(vt[i].e_rdreq));
            chk($sformatf("v%0d mm_wr_req", i),  32'(bus.mm_wr_req),  32'(vt[i].e_wrreq));
            chk($sformatf("v%0d mm_addr", i),    32'(bus.mm_addr),    32'(vt[i].e_mmaddr));
            chk($sformatf("v%0d mm_wr_data", i), bus.mm_wr_data,      vt[i].e_mmwdata);
            chk($sformatf("v%0d hit_cnt", i),    32'(bus.hit_cnt),    32'(vt[i].e_hit));
            chk($sformatf("v%0d miss_cnt", i),   32'(bus.miss_cnt),   32'(vt[i].e_miss));
            @(posedge clk);
            #1;
        end

        // Reset asserted while a refill is outstanding
        drive(1'b1, 1'b0, 10'h006, 32'h0, 1'b0, 128'h0);
        #2 rst = 1'b1;
        #1;
        chk("midrst mm_rd_req", 32'(bus.mm_rd_req), 32'd0);
        chk("midrst stall",     32'(bus.stall),     32'd1);
        chk("midrst hit_cnt",   32'(bus.hit_cnt),   32'd0);
        chk("midrst miss_cnt",  32'(bus.miss_cnt),  32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("postrst stall",     32'(bus.stall),     32'd1);
        chk("postrst mm_rd_req", 32'(bus.mm_rd_req), 32'd0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 10'h006, 32'h0, 1'b1, blk1);
        @(negedge clk);
        chk("refill mm_rd_req", 32'(bus.mm_rd_req), 32'd1);
        chk("refill mm_addr",   32'(bus.mm_addr),   32'h004);
        chk("refill rd_data",   bus.rd_data,        32'h22222222);
        chk("refill stall",     32'(bus.stall),     32'd0);
        chk("refill miss_cnt",  32'(bus.miss_cnt),  32'd1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 10'h005, 32'h0, 1'b0, 128'h0);
        @(negedge clk);
        chk("rehit stall",   32'(bus.stall),   32'd0);
        chk("rehit rd_data", bus.rd_data,      32'h11111111);
        chk("rehit hit_cnt", 32'(bus.hit_cnt), 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 128'h0);

        // Narrow counter saturation
        bus4.mem_read = 1'b1;
        bus4.addr     = 10'h010;
        @(negedge clk);
        chk("sat miss stall", 32'(bus4.stall), 32'd1);
        @(posedge clk);
        #1;
        bus4.mm_ready   = 1'b1;
        bus4.mm_rd_data = blk1;
        @(negedge clk);
        chk("sat refill rd_data", bus4.rd_data, 32'hAAAA0000);
        @(posedge clk);
        #1;
        bus4.mm_ready   = 1'b0;
        bus4.mm_rd_data = 128'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("sat%0d stall", i),   32'(bus4.stall),   32'd0);
            chk($sformatf("sat%0d hit_cnt", i), 32'(bus4.hit_cnt), (i < 15) ? 32'(i) : 32'd15);
            @(posedge clk);
            #1;
        end
        bus4.mem_read = 1'b0;
        @(negedge clk);
        chk("sat final hit_cnt",  32'(bus4.hit_cnt),  32'd15);
        chk("sat final miss_cnt", 32'(bus4.miss_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
